// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the clk_div_ctrl clock divider.
package clk_ctrl_pkg;

  // Default width of the divisor and half-period counter.
  localparam int DEFAULT_W = 16;

  // Controller states:
  //   STOP     - clock held low, counter parked at 0
  //   RUN      - clock running, no divisor change pending
  //   PEND     - clock running, new divisor waits for the next falling toggle
  //   STOPPING - finishing the current high phase before stopping
  typedef enum logic [1:0] {
    STOP     = 2'd0,
    RUN      = 2'd1,
    PEND     = 2'd2,
    STOPPING = 2'd3
  } state_e;

endpackage : clk_ctrl_pkg

// File: rtl/clk_div_ctr.sv
// Half-period counter: counts 0..div_i-1, wraps to 0, and flags the last count.
module clk_div_ctr
  import clk_ctrl_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,   // load 0
  input  logic         cnt_i,   // advance one step
  input  logic [W-1:0] div_i,   // half-period length, never 0
  output logic         tc_o     // counter is at div_i-1
);

  logic [W-1:0] ctr_q;

  assign tc_o = (ctr_q == div_i - W'(1));

  // Counter register: clear has priority, otherwise count and wrap at terminal.
  always_ff @(posedge clk_i) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values;
    // a blocking = here would make evaluation order change the result.
    if (rst_i || clr_i) begin
      ctr_q <= '0;
    end else if (cnt_i) begin
      ctr_q <= tc_o ? '0 : ctr_q + W'(1);
    end
  end

endmodule : clk_div_ctr

// File: rtl/clk_div_ctrl.sv
// Run/stop clock divider with glitch-free divisor change handshake.
// Build option: define CLK_DIV_CTRL_GB_EN to drive clk_o through an SB_GB
// global buffer; without it clk_o comes straight from its register.
module clk_div_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int          W       = DEFAULT_W,
  parameter int unsigned DIV_RST = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         div_req_i,
  input  logic [W-1:0] div_i,
  output logic         busy_o,
  output logic         div_ack_o,
  output logic [W-1:0] div_o,
  output logic         clk_o,
  output logic         rise_o,
  output logic         fall_o
);

  // Reset divisor, with 0 treated as 1 so the counter always has a terminal.
  localparam logic [W-1:0] DivRstC = (DIV_RST == 0) ? W'(1) : W'(DIV_RST);

  function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
    return (d == '0) ? W'(1) : d;
  endfunction

  state_e       state_q, state_d;
  logic         clk_q, clk_d;
  logic         rise_q, rise_d;
  logic         fall_q, fall_d;
  logic         busy_q, busy_d;
  logic         ack_q, ack_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pend_q, pend_d;

  logic ctr_clr;
  logic ctr_cnt;
  logic tc;
  logic accept;

  assign accept = div_req_i && !busy_q;

  clk_div_ctr #(.W(W)) u_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (ctr_clr),
    .cnt_i (ctr_cnt),
    .div_i (div_q),
    .tc_o  (tc)
  );

  // Next-state logic: clock toggling, run/stop sequencing and divisor handoff.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    div_d   = div_q;
    pend_d  = pend_q;
    ctr_clr = 1'b0;
    ctr_cnt = 1'b0;

    // A new request is latched whenever nothing is pending; it can never
    // collide with an apply below because applying needs busy_q set.
    if (accept) begin
      pend_d = clamp_div(div_i);
      busy_d = 1'b1;
    end

    unique case (state_q)
      STOP: begin
        ctr_clr = 1'b1;
        // Stopped: a pending divisor goes live one cycle after it was latched.
        if (busy_q) begin
          div_d  = pend_q;
          ack_d  = 1'b1;
          busy_d = 1'b0;
        end
        // Leaving STOP starts a fresh low phase from ctr=0.
        if (en_i) begin
          state_d = accept ? PEND : RUN;
        end
      end

      RUN, PEND: begin
        if (!en_i && !clk_q) begin
          // Already low: stop at once, any pending divisor is applied in STOP.
          state_d = STOP;
          ctr_clr = 1'b1;
        end else begin
          ctr_cnt = 1'b1;
          if (tc) begin
            clk_d  = !clk_q;
            rise_d = !clk_q;
            fall_d = clk_q;
            // Divisor changes only at a falling toggle so no phase is cut short.
            if (clk_q && busy_q) begin
              div_d  = pend_q;
              ack_d  = 1'b1;
              busy_d = 1'b0;
            end
          end
          if (!en_i) begin
            state_d = tc ? STOP : STOPPING;
          end else if (tc && clk_q && busy_q) begin
            state_d = RUN;
          end else if (accept) begin
            state_d = PEND;
          end
        end
      end

      STOPPING: begin
        // Clock is high here; finish the phase, fall, then park.
        ctr_cnt = 1'b1;
        if (tc) begin
          clk_d   = 1'b0;
          fall_d  = 1'b1;
          state_d = STOP;
          if (busy_q) begin
            div_d  = pend_q;
            ack_d  = 1'b1;
            busy_d = 1'b0;
          end
        end
      end

      default: state_d = STOP;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STOP;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      div_q   <= DivRstC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
    end
  end

  assign busy_o    = busy_q;
  assign div_ack_o = ack_q;
  assign div_o     = div_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;

`ifdef CLK_DIV_CTRL_GB_EN
  SB_GB u_clk_gb (
    .USER_SIGNAL_TO_GLOBAL_BUFFER (clk_q),
    .GLOBAL_BUFFER_OUTPUT         (clk_o)
  );
`else
  assign clk_o = clk_q;
`endif

endmodule : clk_div_ctrl

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: run/stop, divisor handshake, reset abort.
module tb_clk_div_ctrl;

  localparam int W = 16;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         en_i;
  logic         div_req_i;
  logic [W-1:0] div_i;
  logic         busy_o;
  logic         div_ack_o;
  logic [W-1:0] div_o;
  logic         clk_o;
  logic         rise_o;
  logic         fall_o;

  int total = 0;
  int bad   = 0;

  clk_div_ctrl #(.W(W), .DIV_RST(1)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .div_req_i (div_req_i),
    .div_i     (div_i),
    .busy_o    (busy_o),
    .div_ack_o (div_ack_o),
    .div_o     (div_o),
    .clk_o     (clk_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o)
  );

  always #5 clk_i = !clk_i;

  // Advance one clk_i edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Step until rise_o is seen, bounded; an expired bound is a failed comparison.
  task automatic wait_rise(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!rise_o && n < 50);
    check(tag, 32'(rise_o), 32'd1);
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; div_req_i = 1'b0; div_i = '0;
    step(); step();
    rst_i = 1'b0;
    check("rst_clk",  32'(clk_o),     32'd0);
    check("rst_rise", 32'(rise_o),    32'd0);
    check("rst_fall", 32'(fall_o),    32'd0);
    check("rst_busy", 32'(busy_o),    32'd0);
    check("rst_ack",  32'(div_ack_o), 32'd0);
    check("rst_div",  32'(div_o),     32'd1);

    // Divide by 1: clk_o toggles every cycle, rise/fall alternate.
    en_i = 1'b1;
    step();
    check("d1_first_low", 32'(clk_o), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("d1_clk",  32'(clk_o),  32'((i % 2) == 0));
      check("d1_rise", 32'(rise_o), 32'((i % 2) == 0));
      check("d1_fall", 32'(fall_o), 32'((i % 2) != 0));
    end
    // clk_o is low, so dropping en_i stops at once without a fall strobe.
    en_i = 1'b0;
    step();
    check("stop_low_clk",  32'(clk_o),  32'd0);
    check("stop_low_fall", 32'(fall_o), 32'd0);

    // Divisor 3 while stopped: busy for one cycle, then applied with ack.
    div_req_i = 1'b1; div_i = 16'd3;
    step();
    div_req_i = 1'b0;
    check("s3_busy", 32'(busy_o),    32'd1);
    check("s3_ack0", 32'(div_ack_o), 32'd0);
    check("s3_old",  32'(div_o),     32'd1);
    step();
    check("s3_ack",   32'(div_ack_o), 32'd1);
    check("s3_busy0", 32'(busy_o),    32'd0);
    check("s3_div",   32'(div_o),     32'd3);
    step();
    check("s3_ack_once", 32'(div_ack_o), 32'd0);

    // Run at 3, request 5 in the first high cycle: high stays 3, low becomes 5.
    en_i = 1'b1;
    step();
    wait_rise("r3_rise");
    div_req_i = 1'b1; div_i = 16'd5;
    step();
    div_req_i = 1'b0;
    check("r5_busy", 32'(busy_o), 32'd1);
    check("r5_h1",   32'(clk_o),  32'd1);
    step();
    check("r5_h2",   32'(clk_o),  32'd1);
    check("r5_noack", 32'(div_ack_o), 32'd0);
    step();
    check("r5_fall_clk", 32'(clk_o),     32'd0);
    check("r5_fall",     32'(fall_o),    32'd1);
    check("r5_ack",      32'(div_ack_o), 32'd1);
    check("r5_busy0",    32'(busy_o),    32'd0);
    check("r5_div",      32'(div_o),     32'd5);
    for (int i = 0; i < 4; i++) begin
      step();
      check("r5_low", 32'(clk_o), 32'd0);
    end
    step();
    check("r5_rise_clk", 32'(clk_o),  32'd1);
    check("r5_rise",     32'(rise_o), 32'd1);

    // Request 4, then 9 while busy: 9 is dropped, 4 lands at the fall.
    div_req_i = 1'b1; div_i = 16'd4;
    step();
    div_i = 16'd9;
    check("q4_busy", 32'(busy_o), 32'd1);
    step();
    div_req_i = 1'b0;
    step(); step();
    check("q4_still_high", 32'(clk_o), 32'd1);
    step();
    check("q4_fall", 32'(fall_o),    32'd1);
    check("q4_ack",  32'(div_ack_o), 32'd1);
    check("q4_div",  32'(div_o),     32'd4);
    step();
    check("q9_busy", 32'(busy_o),    32'd0);
    check("q9_ack",  32'(div_ack_o), 32'd0);
    check("q9_div",  32'(div_o),     32'd4);

    // Drop en_i one cycle into a 4-cycle high phase.
    wait_rise("st_rise");
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_high", 32'(clk_o),  32'd1);
      check("st_nofall", 32'(fall_o), 32'd0);
    end
    step();
    check("st_fall_clk", 32'(clk_o),  32'd0);
    check("st_fall",     32'(fall_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_hold_clk",  32'(clk_o),  32'd0);
      check("st_hold_fall", 32'(fall_o), 32'd0);
    end

    // Divisor 0 in STOP clamps to 1, ack two cycles after the request cycle.
    div_req_i = 1'b1; div_i = 16'd0;
    step();
    div_req_i = 1'b0;
    check("z_busy", 32'(busy_o), 32'd1);
    check("z_old",  32'(div_o),  32'd4);
    step();
    check("z_ack", 32'(div_ack_o), 32'd1);
    check("z_div", 32'(div_o),     32'd1);

    // en_i falls while PEND: pending divisor applies at the stopping fall.
    en_i = 1'b1;
    step();
    div_req_i = 1'b1; div_i = 16'd2;
    step();
    div_req_i = 1'b0; en_i = 1'b0;
    check("pf_busy", 32'(busy_o), 32'd1);
    check("pf_high", 32'(clk_o),  32'd1);
    step();
    check("pf_clk",  32'(clk_o),     32'd0);
    check("pf_fall", 32'(fall_o),    32'd1);
    check("pf_ack",  32'(div_ack_o), 32'd1);
    check("pf_div",  32'(div_o),     32'd2);
    check("pf_busy0", 32'(busy_o),   32'd0);

    // Reset while PEND: everything back to reset values, no ack.
    en_i = 1'b1;
    step();
    div_req_i = 1'b1; div_i = 16'd7;
    step();
    div_req_i = 1'b0;
    check("rp_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1; en_i = 1'b0;
    step();
    rst_i = 1'b0;
    check("rp_clk",  32'(clk_o),     32'd0);
    check("rp_rise", 32'(rise_o),    32'd0);
    check("rp_fall", 32'(fall_o),    32'd0);
    check("rp_busy0", 32'(busy_o),   32'd0);
    check("rp_ack",  32'(div_ack_o), 32'd0);
    check("rp_div",  32'(div_o),     32'd1);
    step();
    check("rp_ack_late", 32'(div_ack_o), 32'd0);
    check("rp_div_late", 32'(div_o),     32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_clk_div_ctrl

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter W, default 16: width of divisor and half-period counter.
REQ-002 SHALL have parameter DIV_RST, default 1: divisor loaded at reset, in clk_i cycles per half-period.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en_i  input  1  run request; high = generate clock, low = stop clock low.
REQ-006 SHALL have port div_req_i  input  1  divisor-change request, qualified with div_i.
REQ-007 SHALL have port div_i  input  W  requested half-period in clk_i cycles.
REQ-008 SHALL have port busy_o  output  1  divisor change pending; new requests ignored while high.
REQ-009 SHALL have port div_ack_o  output  1  one-cycle strobe: requested divisor now in effect.
REQ-010 SHALL have port div_o  output  W  divisor currently in effect.
REQ-011 SHALL have port clk_o  output  1  generated clock, registered, glitch-free.
REQ-012 SHALL have port rise_o  output  1  strobe, high in the first clk_i cycle of each clk_o high phase.
REQ-013 SHALL have port fall_o  output  1  strobe, high in the first clk_i cycle of each clk_o low phase.

Function
REQ-014 SHALL implement FSM states STOP, RUN, PEND, STOPPING.
REQ-015 SHALL, in RUN/PEND/STOPPING, count ctr 0..div_o-1 and toggle clk_o in the cycle after ctr==div_o-1, reloading ctr to 0; period = 2*div_o clk_i cycles, 50% duty.
REQ-016 SHALL treat div_i==0 as 1; div_o is never 0.
REQ-017 SHALL accept a request when div_req_i==1 and busy_o==0, latch div_i into a pending register, and raise busy_o the next cycle.
REQ-018 SHALL, in RUN, enter PEND on accept; the pending divisor takes effect at the next 1->0 toggle of clk_o; never mid-phase.
REQ-019 SHALL, in STOP, apply an accepted divisor immediately: div_o updates and div_ack_o pulses one cycle after accept.
REQ-020 SHALL pulse div_ack_o for exactly one cycle, in the first cycle the new div_o is visible, with busy_o dropping in that same cycle.
REQ-021 SHALL, on en_i low in RUN, enter STOPPING; clk_o completes its current high phase, falls, then holds 0 with ctr=0 in STOP; if clk_o is already low, enter STOP at once.
REQ-022 SHALL, if en_i falls while in PEND, apply the pending divisor at the same falling edge that stops the clock, and pulse div_ack_o as normal.
REQ-023 SHALL, on en_i high in STOP, enter RUN; clk_o begins with a full low phase of div_o cycles.
REQ-024 SHALL make rise_o/fall_o coincide exactly with the clk_o transitions and never assert both in one cycle.
REQ-025 SHALL ignore div_req_i while busy_o is high; it is not queued.

Reset
REQ-026 SHALL, on rst_i high at a clk_i edge, set state STOP, ctr 0, clk_o 0, rise_o 0, fall_o 0, busy_o 0, div_ack_o 0, div_o DIV_RST (clamped to 1), and clear pending.
REQ-027 SHALL abandon any pending change on reset mid-operation, with no div_ack_o.

Configuration
REQ-028 SHALL, with CLK_DIV_CTRL_GB_EN defined, route the clk_o register through an SB_GB global buffer instance to drive clk_o.
REQ-029 SHALL, without CLK_DIV_CTRL_GB_EN, drive clk_o directly from the register; cycle behaviour is identical in both cases.

Structure
REQ-030 SHALL place the FSM state enum and default width constant in the shared package clk_ctrl_pkg.
REQ-031 SHALL put the half-period counter (load, count, terminal flag) in sub-module clk_div_ctr.

Verification
REQ-032 SHALL cover: reset, en_i=1, DIV_RST=1 -> clk_o period 2 cycles, rise_o/fall_o alternate every cycle.
REQ-033 SHALL cover: RUN with div_o=3, request div_i=5 mid high phase -> busy_o high, high phase stays 3 cycles, low phase 5 cycles, div_ack_o at the fall.
REQ-034 SHALL cover: div_i=0 in STOP -> div_o=1 and div_ack_o two cycles after the request cycle.
REQ-035 SHALL cover: en_i dropped one cycle into a 4-cycle high phase -> clk_o stays high 3 more cycles, falls, and holds 0; fall_o pulses once.
REQ-036 SHALL cover: second div_req_i=9 while busy_o high -> ignored; div_o takes only the first value.
REQ-037 SHALL cover: rst_i asserted while PEND -> all outputs at reset values next cycle, no div_ack_o, div_o=DIV_RST.
